// File: rtl/ofs_fim_axis_tx_framer_if.sv
// Bus bundle for the AXIS transmit framer: command, unframed data and framed AXIS output.
// master = the host/DMA side feeding commands and data; slave = the framer itself.
interface ofs_fim_axis_tx_framer_if #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned TUSER_WIDTH = 1
);
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [LEN_WIDTH-1:0]   cmd_len;
  logic [TUSER_WIDTH-1:0] cmd_tuser;

  logic                   d_valid;
  logic                   d_ready;
  logic [TDATA_WIDTH-1:0] d_data;

  logic                   m_tready;
  logic                   m_tvalid;
  logic [TDATA_WIDTH-1:0] m_tdata;
  logic [TKEEP_WIDTH-1:0] m_tkeep;
  logic                   m_tlast;
  logic [TUSER_WIDTH-1:0] m_tuser;

  modport master (
    output cmd_valid, cmd_len, cmd_tuser, d_valid, d_data, m_tready,
    input  cmd_ready, d_ready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_tuser, d_valid, d_data, m_tready,
    output cmd_ready, d_ready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );
endinterface

// File: rtl/ofs_fim_axis_tx_framer.sv
// AXIS transmit framer: byte-length command + unframed words -> registered AXIS packet.
// Define OFS_FIM_AXIS_TX_FRAMER_STATS_EN to build the pkt_cnt packet counter.
module ofs_fim_axis_tx_framer #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned TUSER_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  ofs_fim_axis_tx_framer_if.slave   bus,
  output logic                      busy,
  output logic [31:0]               pkt_cnt
);
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int unsigned BpbLog      = $clog2(TKEEP_WIDTH);
  localparam int unsigned BeatW       = LEN_WIDTH + 1;

  typedef enum logic {StIdle, StData} state_e;

  state_e                 state_q, state_d;
  logic [BeatW-1:0]       remaining_q, remaining_d;
  logic [TKEEP_WIDTH-1:0] last_keep_q, last_keep_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                   cmd_ready_q;

  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [TKEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TUSER_WIDTH-1:0] otuser_q, otuser_d;

  logic                   cmd_hs;
  logic                   d_ready;
  logic                   d_hs;
  logic [BeatW-1:0]       beats;
  logic [LEN_WIDTH-1:0]   len_rem;

  // One extra bit keeps the round-up from overflowing at maximum length.
  assign beats   = (BeatW'(bus.cmd_len) + BeatW'(TKEEP_WIDTH - 1)) >> BpbLog;
  assign len_rem = bus.cmd_len & LEN_WIDTH'(TKEEP_WIDTH - 1);

  assign cmd_hs  = bus.cmd_valid && cmd_ready_q;
  assign d_ready = (state_q == StData) && !rst && (bus.m_tready || !tvalid_q);
  assign d_hs    = bus.d_valid && d_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    last_keep_d = last_keep_q;
    tuser_d     = tuser_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tkeep_d     = tkeep_q;
    tdata_d     = tdata_q;
    otuser_d    = otuser_q;

    if (tvalid_q && bus.m_tready) tvalid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          remaining_d = beats;
          last_keep_d = (len_rem == '0) ? '1 : ~({TKEEP_WIDTH{1'b1}} << len_rem);
          tuser_d     = bus.cmd_tuser;
          if (beats != '0) state_d = StData;
        end
      end
      StData: begin
        if (d_hs) begin
          tvalid_d = 1'b1;
          tdata_d  = bus.d_data;
          otuser_d = tuser_q;
          if (remaining_q == BeatW'(1)) begin
            tlast_d = 1'b1;
            tkeep_d = last_keep_q;
            state_d = StIdle;
          end else begin
            tlast_d     = 1'b0;
            tkeep_d     = '1;
            remaining_d = remaining_q - BeatW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      last_keep_q <= '1;
      tuser_q     <= '0;
      cmd_ready_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      last_keep_q <= last_keep_d;
      tuser_q     <= tuser_d;
      // Registered so cmd_ready never depends combinationally on an input.
      cmd_ready_q <= (state_d == StIdle);
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  always_ff @(posedge clk) begin
    tdata_q  <= tdata_d;
    tkeep_q  <= tkeep_d;
    otuser_q <= otuser_d;
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.d_ready   = d_ready;
  assign bus.m_tvalid  = tvalid_q;
  assign bus.m_tdata   = tdata_q;
  assign bus.m_tkeep   = tkeep_q;
  assign bus.m_tlast   = tlast_q;
  assign bus.m_tuser   = otuser_q;
  assign busy          = (state_q == StData);

`ifdef OFS_FIM_AXIS_TX_FRAMER_STATS_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else if (tvalid_q && bus.m_tready && tlast_q) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif
endmodule

// File: doc/ofs_fim_axis_tx_framer.md
# ofs_fim_axis_tx_framer

AXI-Stream transmit framer: takes a per-packet byte-length command plus an unframed stream of data words and emits a framed AXIS packet with computed `tkeep` and `tlast`. It is the source end of the AXIS links carried by the FIM pipeline registers. It turns DMA/host data into well-formed packets that a downstream AXIS register or mux can consume. Output is fully registered, so it can drive a pipeline register directly.

## Interface
Parameters:
- `TDATA_WIDTH`, 64: data width in bits; `TDATA_WIDTH/8` must be a power of 2.
- `LEN_WIDTH`, 16: byte-length field width.
- `TUSER_WIDTH`, 1: sideband width, copied onto every beat of the packet.
- `TKEEP_WIDTH`, `TDATA_WIDTH/8`: derived; `BPB` = `TKEEP_WIDTH` bytes per beat.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_len`  in  LEN_WIDTH  packet length in bytes.
- `cmd_tuser`  in  TUSER_WIDTH  sideband for the packet.
- `d_valid`  in  1  data word valid.
- `d_ready`  out  1  data word accepted when `d_valid && d_ready`.
- `d_data`  in  TDATA_WIDTH  data word, byte 0 in bits [7:0].
- `m_tready`  in  1  downstream ready.
- `m_tvalid`  out  1  output beat valid.
- `m_tdata`  out  TDATA_WIDTH  output data.
- `m_tkeep`  out  TKEEP_WIDTH  byte enables, contiguous from bit 0.
- `m_tlast`  out  1  last beat of packet.
- `m_tuser`  out  TUSER_WIDTH  latched `cmd_tuser`.
- `busy`  out  1  high in DATA state.
- `pkt_cnt`  out  32  packets emitted (see Configuration).

## Operation
- **States:** IDLE and DATA.
- **IDLE:** `cmd_ready`=1 and `d_ready`=0.
  - On a command handshake, latch `beats` = (`cmd_len` + BPB-1) >> log2(BPB), computed LEN_WIDTH+1 bits wide so there is no overflow at max length.
  - Latch `last_keep` = (1<<r)-1, where r = `cmd_len` mod BPB; r=0 gives all ones.
  - Latch `cmd_tuser`.
  - If `beats` > 0, go to DATA. `cmd_len`=0 is consumed with no output and the block stays in IDLE.
- **DATA:** `cmd_ready`=0 and `d_ready` = `m_tready || !m_tvalid`.
  - Each data handshake loads the output register: `m_tdata`=`d_data` and `m_tuser`=latched sideband.
  - If `remaining`==1: `m_tlast`=1, `m_tkeep`=`last_keep`, and go to IDLE.
  - Otherwise: `m_tlast`=0, `m_tkeep`=all ones, and decrement `remaining`.
- **Output register:**
  - Loads only when `m_tready || !m_tvalid`.
  - `m_tvalid` clears when a beat is taken and no new beat is loaded.
  - All `m_*` signals hold stable while `m_tvalid && !m_tready`.
- **Data ordering:** `d_data` words arriving while the block is in IDLE are not accepted. The data source must not run ahead of its command.
- **Reset:**
  - `m_tvalid`=0, `m_tlast`=0, `cmd_ready`=0, `d_ready`=0, `busy`=0, `pkt_cnt`=0; state returns to IDLE.
  - A reset mid-packet drops the partial packet; no `tlast` is emitted.
  - `m_tdata`, `m_tkeep` and `m_tuser` are don't-care while `m_tvalid`=0.

## Timing
- **Command to data:** a command accepted in cycle N raises `d_ready` in cycle N+1 at the earliest.
- **Data to output:** a data handshake in cycle N gives `m_tvalid`=1 in cycle N+1. Latency is 1 cycle.
- **Throughput:** 1 beat/cycle inside a packet while `m_tready`=1.
- **Between packets:** exactly one IDLE cycle separates packets. A command can be accepted in the cycle after the `tlast` beat is loaded.
- **Backpressure:**
  - `d_ready` follows `m_tready` combinationally while in DATA.
  - `cmd_ready` has no combinational path from any input.
- **Simultaneous events:** when `m_tready` drops in the same cycle a data word is offered with `m_tvalid`=1, the word is not accepted.

## Configuration
- Macro: `OFS_FIM_AXIS_TX_FRAMER_STATS_EN`.
- **Defined:** `pkt_cnt` increments by 1 when a beat with `m_tvalid && m_tready && m_tlast` is accepted. It wraps from 0xFFFF_FFFF to 0 and resets to 0.
- **Undefined:** `pkt_cnt` is tied to 0 and no counter logic is built. The port is present in both builds.

## Test plan
- TDATA_WIDTH=64, `cmd_len`=8, data 0x0706050403020100 -> one beat, `m_tkeep`=0xFF, `m_tlast`=1, sent 1 cycle after the data handshake.
- `cmd_len`=13 with two data words -> beat 1 `m_tkeep`=0xFF, `m_tlast`=0; beat 2 `m_tkeep`=0x1F, `m_tlast`=1; `busy` low after beat 2 is loaded.
- `cmd_len`=32 with `m_tready` held low for 3 cycles after beat 2 -> `m_*` stable for those 3 cycles, `d_ready`=0, no data lost; 4 beats in order with `tlast` on beat 4.
- `cmd_len`=0 -> command consumed, no `m_tvalid`, `cmd_ready`=1 again the next cycle, `pkt_cnt` unchanged.
- `cmd_len`=24 with `rst` asserted after beat 1 -> `m_tvalid`=0 and `cmd_ready`=0 during reset; next command `cmd_len`=8 produces a single clean beat with `tlast`.
- Stats build, three back-to-back packets of lengths 1, 9 and 64 -> `tkeep` on the last beats is 0x01, 0x01 and 0xFF; `pkt_cnt`=3; one idle cycle between packets.
